// File: rtl/vm_display_pkg.sv
// Shared definitions for the vending-machine display path.
package vm_display_pkg;

    localparam int unsigned BCD_DIGITS  = 4;
    localparam int unsigned BCD_W       = 4 * BCD_DIGITS;
    localparam int unsigned MAX_DISPLAY = 9999;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } fsm_state_e;

    // Leading-zero mask from the upper three BCD digits; the units digit always shows.
    function automatic logic [3:0] lead_zero_mask(input logic [BCD_W-5:0] upper_bcd);
        logic b3;
        logic b2;
        logic b1;
        b3 = (upper_bcd[11:8] == 4'd0);
        b2 = b3 & (upper_bcd[7:4] == 4'd0);
        b1 = b2 & (upper_bcd[3:0] == 4'd0);
        return {b3, b2, b1, 1'b0};
    endfunction

endpackage

// File: rtl/bcd_add3_nibble.sv
// Double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_add3_nibble (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib_c
);

    assign o_nib_c = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bin2bcd_display_feed.sv
// Iterative binary-to-BCD converter feeding the 4-digit display multiplexer.
// Digits only change on completion; requests arriving while busy are held 1-deep.
module bin2bcd_display_feed
    import vm_display_pkg::*;
#(
    parameter int unsigned BIN_W   = 14,
    parameter int unsigned MAX_VAL = MAX_DISPLAY
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       digit1,
    output logic [3:0]       digit2,
    output logic [3:0]       digit3,
    output logic [3:0]       digit4,
    output logic [3:0]       lz_mask
);

    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_CLAMP = BIN_W'(MAX_VAL);

    fsm_state_e       r_state;
    fsm_state_e       w_state_next;
    logic [SR_W-1:0]  r_shift;
    logic [SR_W-1:0]  w_shift_add;
    logic [CNT_W-1:0] r_cnt;
    logic [BIN_W-1:0] r_val;
    logic             r_val_ovf;
    logic             r_pend_vld;
    logic [BIN_W-1:0] r_pend_val;

    logic             w_capture;
    logic [BIN_W-1:0] w_src;
    logic             w_pend_set;
    logic             w_load;
    logic             w_shift_en;
    logic             w_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_SHIFT;
            S_SHIFT: if (r_cnt == CNT_W'(1)) w_state_next = S_DONE;
            S_DONE:  w_state_next = (start || r_pend_vld) ? S_LOAD : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // A start in DONE bypasses the pending slot; it is newer than anything held there.
    always_comb begin
        w_capture  = 1'b0;
        w_src      = bin_in;
        w_pend_set = 1'b0;
        w_load     = 1'b0;
        w_shift_en = 1'b0;
        w_fin      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_capture = start;
            end
            S_LOAD: begin
                w_load     = 1'b1;
                w_pend_set = start;
            end
            S_SHIFT: begin
                w_shift_en = 1'b1;
                w_pend_set = start;
            end
            S_DONE: begin
                w_fin     = 1'b1;
                w_capture = start | r_pend_vld;
                w_src     = start ? bin_in : r_pend_val;
            end
            default: begin
                w_fin = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_vld <= 1'b0;
            r_pend_val <= '0;
        end else if (w_pend_set) begin
            r_pend_vld <= 1'b1;
            r_pend_val <= bin_in;
        end else if (w_fin) begin
            r_pend_vld <= 1'b0;
        end
    end

    // Clamp at capture so the converter never sees a value beyond four digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val     <= '0;
            r_val_ovf <= 1'b0;
        end else if (w_capture) begin
            r_val     <= (w_src > MAX_CLAMP) ? MAX_CLAMP : w_src;
            r_val_ovf <= (w_src > MAX_CLAMP);
        end
    end

    assign w_shift_add[BIN_W-1:0] = r_shift[BIN_W-1:0];

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3_nibble u_add3 (
            .i_nib   (r_shift[BIN_W + 4*g +: 4]),
            .o_nib_c (w_shift_add[BIN_W + 4*g +: 4])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_shift <= {BCD_W'(0), r_val};
            r_cnt   <= CNT_W'(BIN_W);
        end else if (w_shift_en) begin
            r_shift <= w_shift_add << 1;
            r_cnt   <= r_cnt - CNT_W'(1);
        end
    end

    // busy stays high through the done cycle so it falls one cycle after the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            digit1  <= 4'd0;
            digit2  <= 4'd0;
            digit3  <= 4'd0;
            digit4  <= 4'd0;
            lz_mask <= 4'b1110;
        end else begin
            busy <= (w_state_next != S_IDLE) | w_fin;
            done <= w_fin;
            if (w_fin) begin
                ovf     <= r_val_ovf;
                digit1  <= r_shift[BIN_W      +: 4];
                digit2  <= r_shift[BIN_W + 4  +: 4];
                digit3  <= r_shift[BIN_W + 8  +: 4];
                digit4  <= r_shift[BIN_W + 12 +: 4];
                lz_mask <= lead_zero_mask(r_shift[SR_W-1 -: (BCD_W-4)]);
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_display_feed.sv
// Self-checking bench for bin2bcd_display_feed: directed cases plus randomized
// conversions checked against a decimal-arithmetic reference model.
module tb_bin2bcd_display_feed;

    localparam int unsigned BIN_W = 14;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [BIN_W-1:0] bin_in;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       digit1;
    logic [3:0]       digit2;
    logic [3:0]       digit3;
    logic [3:0]       digit4;
    logic [3:0]       lz_mask;

    int n_cmp = 0;
    int n_bad = 0;

    bin2bcd_display_feed #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .ovf     (ovf),
        .digit1  (digit1),
        .digit2  (digit2),
        .digit3  (digit3),
        .digit4  (digit4),
        .lz_mask (lz_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    // Reference: clamp, then split into decimal digits with plain arithmetic.
    function automatic int clamp(input int v);
        return (v > 9999) ? 9999 : v;
    endfunction

    function automatic int exp_lz(input int v);
        int c;
        c = clamp(v);
        return ((c < 1000) ? 8 : 0) + ((c < 100) ? 4 : 0) + ((c < 10) ? 2 : 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int v);
        start  = 1'b1;
        bin_in = BIN_W'(v);
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_result(input string tag, input int v);
        int c;
        c = clamp(v);
        chk({tag, ".done"},   32'(done),    32'd1);
        chk({tag, ".busy"},   32'(busy),    32'd1);
        chk({tag, ".d1"},     32'(digit1),  32'(c % 10));
        chk({tag, ".d2"},     32'(digit2),  32'((c / 10) % 10));
        chk({tag, ".d3"},     32'(digit3),  32'((c / 100) % 10));
        chk({tag, ".d4"},     32'(digit4),  32'(c / 1000));
        chk({tag, ".lz"},     32'(lz_mask), 32'(exp_lz(v)));
        chk({tag, ".ovf"},    32'(ovf),     32'(v > 9999));
    endtask

    task automatic end_idle(input string tag);
        tick();
        chk({tag, ".done_fall"}, 32'(done), 32'd0);
        chk({tag, ".busy_fall"}, 32'(busy), 32'd0);
    endtask

    task automatic conv(input string tag, input int v);
        int n;
        do_start(v);
        wait_done(n);
        chk({tag, ".latency"}, 32'(n), 32'd16);
        check_result(tag, v);
        end_idle(tag);
    endtask

    task automatic count_done(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done === 1'b1) cnt++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".busy"}, 32'(busy),    32'd0);
        chk({tag, ".done"}, 32'(done),    32'd0);
        chk({tag, ".ovf"},  32'(ovf),     32'd0);
        chk({tag, ".dig"},  32'({digit4, digit3, digit2, digit1}), 32'd0);
        chk({tag, ".lz"},   32'(lz_mask), 32'd14);
    endtask

    // Background monitor: held digits, digit range, and done-to-done spacing.
    int         cyc = 0;
    int         last_done = -1;
    bit         mon_valid = 1'b0;
    logic [15:0] mon_prev;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            mon_valid = 1'b0;
            last_done = -1;
        end else begin
            if (mon_valid && done !== 1'b1)
                chk("mon.hold", 32'({digit4, digit3, digit2, digit1}), 32'(mon_prev));
            chk("mon.range", 32'(digit1 <= 9 && digit2 <= 9 && digit3 <= 9 && digit4 <= 9), 32'd1);
            if (done === 1'b1) begin
                if (last_done >= 0) chk("mon.spacing", 32'((cyc - last_done) >= 16), 32'd1);
                last_done = cyc;
            end
            mon_prev  = {digit4, digit3, digit2, digit1};
            mon_valid = 1'b1;
        end
    end

    initial begin
        int n;
        int cnt;
        int a;
        int b;
        int last;
        int nb;

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        #12;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        conv("zero", 0);
        conv("v1234", 1234);
        conv("v10000", 10000);
        conv("v7", 7);

        // Two requests while busy: only the last one is served after the first.
        do_start(500);
        tick(); tick();
        do_start(42);
        tick(); tick();
        do_start(81);
        wait_done(n);
        chk("pend.lat1", 32'(n), 32'd10);
        check_result("pend500", 500);
        wait_done(n);
        chk("pend.lat2", 32'(n), 32'd16);
        check_result("pend81", 81);
        end_idle("pend81");
        count_done(30, cnt);
        chk("pend.no42", 32'(cnt), 32'd0);

        // Start arriving in the DONE-state cycle is queued behind the current result.
        do_start(321);
        repeat (15) tick();
        do_start(4567);
        check_result("dcyc321", 321);
        wait_done(n);
        chk("dcyc.lat", 32'(n), 32'd16);
        check_result("dcyc4567", 4567);
        end_idle("dcyc4567");

        // Reset in the middle of a conversion.
        conv("v12345", 12345);
        do_start(9999);
        repeat (8) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(25, cnt);
        chk("midrst.nodone", 32'(cnt), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);

        // Randomized conversions, some with extra requests while busy.
        for (int k = 0; k < 40; k++) begin
            a    = int'($urandom_range(0, 16383));
            nb   = int'($urandom_range(0, 2));
            last = a;
            do_start(a);
            for (int j = 0; j < nb; j++) begin
                tick();
                b = int'($urandom_range(0, 16383));
                do_start(b);
                last = b;
            end
            wait_done(n);
            chk("rnd.lat1", 32'(n), 32'(16 - 2 * nb));
            check_result("rnd1", a);
            if (nb > 0) begin
                wait_done(n);
                chk("rnd.lat2", 32'(n), 32'd16);
                check_result("rnd2", last);
            end
            end_idle("rnd");
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
